// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
// Divides the system clock down to a pixel tick and runs the horizontal and
// vertical pixel counters. Sync, video-enable and frame-start are decoded from
// the next counter values, so they stay aligned with pixelX/pixelY.
// Optional feature macro: VGA_SYNC_TEST_PATTERN_EN adds the rgbPattern output,
// which carries eight vertical colour bars.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        hSync,
    output logic        vSync,
    output logic        videoON,
    output logic        pTick,
    output logic [9:0]  pixelX,
    output logic [9:0]  pixelY,
`ifdef VGA_SYNC_TEST_PATTERN_EN
    output logic [11:0] rgbPattern,
`endif
    output logic        frameStart
);

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_DISPLAY + H_FRONT + H_SYNC;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_DISPLAY + V_FRONT + V_SYNC;
    localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic SYNC_ACT   = (SYNC_POL != 0);

    // The counters are 10 bits wide, so the raster cannot exceed 1024 in
    // either direction.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_sync_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_tick;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;
    logic             w_x_wrap;
    logic             w_video;
    logic             w_hs;
    logic             w_vs;
    logic             r_video;
    logic             r_hs;
    logic             r_vs;
    logic             r_frame;

    // Divider wrap and the counter values that the next pixel tick will load.
    always_comb begin
        w_div_next = (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
        w_x_wrap   = (r_x == 10'(H_TOTAL - 1));
        w_x_next   = w_x_wrap ? '0 : r_x + 10'd1;
        w_y_next   = r_y;
        if (w_x_wrap) begin
            w_y_next = (r_y == 10'(V_TOTAL - 1)) ? '0 : r_y + 10'd1;
        end
    end

    // Sync and video decode from the next counter values, so the registered
    // copies line up with the registered counters.
    always_comb begin
        w_video = (int'(w_x_next) < H_DISPLAY) && (int'(w_y_next) < V_DISPLAY);
        w_hs    = ~SYNC_ACT;
        w_vs    = ~SYNC_ACT;
        if (int'(w_x_next) >= H_SYNC_START && int'(w_x_next) < H_SYNC_END) begin
            w_hs = SYNC_ACT;
        end
        if (int'(w_y_next) >= V_SYNC_START && int'(w_y_next) < V_SYNC_END) begin
            w_vs = SYNC_ACT;
        end
    end

    // Pixel-tick divider; the tick is registered so it is low during reset
    // even when CLK_DIV is 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_next;
            r_tick <= (w_div_next == DIV_W'(CLK_DIV - 1));
        end
    end

    // Raster counters and decoded outputs advance only on a pixel tick;
    // frameStart is a single-clock pulse on the tick that lands on (0,0).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x     <= 10'(H_TOTAL - 1);
            r_y     <= 10'(V_TOTAL - 1);
            r_video <= 1'b0;
            r_hs    <= ~SYNC_ACT;
            r_vs    <= ~SYNC_ACT;
            r_frame <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            if (r_tick) begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_video <= w_video;
                r_hs    <= w_hs;
                r_vs    <= w_vs;
                r_frame <= (w_x_next == '0) && (w_y_next == '0);
            end
        end
    end

`ifdef VGA_SYNC_TEST_PATTERN_EN
    localparam int BAR_W = (H_DISPLAY / 8 > 0) ? H_DISPLAY / 8 : 1;

    logic [2:0]  w_bar;
    logic [11:0] w_rgb;
    logic [11:0] r_rgb;

    // Bar index from the next horizontal count, blanked outside the visible area.
    always_comb begin
        w_bar = 3'(int'(w_x_next) / BAR_W);
        w_rgb = '0;
        if (w_video) begin
            w_rgb = {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}};
        end
    end

    // Test colour registered on the same tick as videoON.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
        end else if (r_tick) begin
            r_rgb <= w_rgb;
        end
    end

    assign rgbPattern = r_rgb;
`endif

    assign hSync      = r_hs;
    assign vSync      = r_vs;
    assign videoON    = r_video;
    assign pTick      = r_tick;
    assign pixelX     = r_x;
    assign pixelY     = r_y;
    assign frameStart = r_frame;

endmodule
